// File: rtl/l2_conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : l2_conv_pkg
//  Purpose  : Shared layer-2 convolution types, widths and the saturating
//             bias-add helper used by the layer-2 bias stages.
//  Revision : 1.0  initial release
// ============================================================================
package l2_conv_pkg;

  // Datapath widths
  localparam int L2_ACC_W = 22;
  localparam int L2_SEL_W = 3;
  localparam int L2_SUM_W = L2_ACC_W + 1;

  // Signed limits of an L2_ACC_W-bit two's complement word
  localparam logic [L2_ACC_W-1:0] L2_ACC_MAX = {1'b0, {(L2_ACC_W-1){1'b1}}};
  localparam logic [L2_ACC_W-1:0] L2_ACC_MIN = {1'b1, {(L2_ACC_W-1){1'b0}}};

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } l2_state_t;

  // Result of a saturating add: clamped value plus clamp indicator
  typedef struct packed {
    logic [L2_ACC_W-1:0] val;
    logic                ovf;
  } l2_sat_t;

  // Sign-extend both operands by one bit, add, then clamp back to L2_ACC_W.
  // Overflow shows up as a disagreement between the two top sum bits; the
  // very top bit then carries the true sign and selects the clamp direction.
  function automatic l2_sat_t l2_sat_add(input logic [L2_ACC_W-1:0] a,
                                         input logic [L2_ACC_W-1:0] b);
    logic [L2_SUM_W-1:0] sum;
    l2_sat_t             res;
    sum     = {a[L2_ACC_W-1], a} + {b[L2_ACC_W-1], b};
    res.val = sum[L2_ACC_W-1:0];
    res.ovf = 1'b0;
    if (sum[L2_SUM_W-1] != sum[L2_ACC_W-1]) begin
      res.ovf = 1'b1;
      res.val = sum[L2_SUM_W-1] ? L2_ACC_MIN : L2_ACC_MAX;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_bias_addsat.sv
`default_nettype none
// ============================================================================
//  Module   : l2_bias_addsat
//  Purpose  : Combinational accumulator + bias add with signed saturation and
//             optional ReLU. Shared by the layer bias stages.
//  Revision : 1.0  initial release
// ============================================================================
module l2_bias_addsat
  import l2_conv_pkg::*;
#(
  parameter int RELU_EN = 1
) (
  input  logic [L2_ACC_W-1:0] i_acc,
  input  logic [L2_ACC_W-1:0] i_bias,
  output logic [L2_ACC_W-1:0] o_res,
  output logic                o_ovf
);

  l2_sat_t w_sat;

  // Saturating add, then ReLU on the clamped value; ReLU never flags overflow
  always_comb begin
    w_sat = l2_sat_add(i_acc, i_bias);
    o_ovf = w_sat.ovf;
    o_res = w_sat.val;
    if ((RELU_EN != 0) && w_sat.val[L2_ACC_W-1]) begin
      o_res = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_bias_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : l2_bias_sequencer
//  Purpose  : Layer-2 bias stage sequencer. Walks channel/pixel counters over
//             one frame, drives the external bias mux select, adds the bias
//             with saturation/ReLU and emits results on a valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
module l2_bias_sequencer
  import l2_conv_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int PIX_NUM  = 64,
  parameter int RELU_EN  = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                Start_i,
  output logic                Busy_o,
  output logic                Done_o,
  input  logic                AccValid_i,
  output logic                AccReady_o,
  input  logic [L2_ACC_W-1:0] Acc_i,
  output logic [L2_SEL_W-1:0] BiasSel_o,
  input  logic [L2_ACC_W-1:0] Bias_i,
  output logic                OutValid_o,
  input  logic                OutReady_i,
  output logic [L2_ACC_W-1:0] Out_o,
  output logic [L2_SEL_W-1:0] OutChan_o,
  output logic                OutLast_o,
  output logic                Ovf_o
);

  // Pixel counter is at least one bit wide so PIX_NUM==1 still elaborates
  localparam int c_pix_w = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
  localparam logic [L2_SEL_W-1:0] c_chan_last = L2_SEL_W'(CHANNELS - 1);
  localparam logic [c_pix_w-1:0]  c_pix_last  = c_pix_w'(PIX_NUM - 1);

  l2_state_t           r_state;
  l2_state_t           w_next_state;
  logic [L2_SEL_W-1:0] r_chan;
  logic [c_pix_w-1:0]  r_pix;
  logic [L2_ACC_W-1:0] r_out;
  logic [L2_SEL_W-1:0] r_out_chan;
  logic                r_out_last;
  logic                r_out_valid;
  logic                r_ovf;
  logic                r_done;

  logic                w_start;
  logic                w_out_free;
  logic                w_acc_ready;
  logic                w_accept;
  logic                w_last_word;
  logic [L2_ACC_W-1:0] w_res;
  logic                w_ovf;

  // Handshake qualifiers. The output slot is free when empty or when it is
  // being drained this cycle, which gives full throughput with ready held.
  assign w_start     = (r_state == IDLE) && Start_i;
  assign w_out_free  = !r_out_valid || OutReady_i;
  assign w_acc_ready = (r_state == RUN) && w_out_free;
  assign w_accept    = AccValid_i && w_acc_ready;
  assign w_last_word = (r_chan == c_chan_last) && (r_pix == c_pix_last);

  // Bias arithmetic; Bias_i already reflects r_chan through the external mux
  l2_bias_addsat #(
    .RELU_EN (RELU_EN)
  ) u_addsat (
    .i_acc  (Acc_i),
    .i_bias (Bias_i),
    .o_res  (w_res),
    .o_ovf  (w_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (Start_i) w_next_state = RUN;
      RUN:     if (w_accept && w_last_word) w_next_state = DRAIN;
      DRAIN:   if (w_out_free) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Channel/pixel counters: cleared on start, advanced per accepted word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_chan <= '0;
      r_pix  <= '0;
    end else if (w_start) begin
      r_chan <= '0;
      r_pix  <= '0;
    end else if (w_accept) begin
      if (r_chan == c_chan_last) begin
        r_chan <= '0;
        r_pix  <= (r_pix == c_pix_last) ? '0 : r_pix + 1'b1;
      end else begin
        r_chan <= r_chan + 1'b1;
      end
    end
  end

  // Output register: load on accept, otherwise drop valid once taken
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out       <= '0;
      r_out_chan  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_res;
      r_out_chan  <= r_chan;
      r_out_last  <= w_last_word;
      r_out_valid <= 1'b1;
    end else if (OutReady_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky saturation flag, scoped to one frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_ovf <= 1'b0;
    end else if (w_accept && w_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  // Done pulse registered on the DRAIN->IDLE edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DRAIN) && w_out_free;
    end
  end

  assign Busy_o     = (r_state == RUN) || (r_state == DRAIN);
  assign Done_o     = r_done;
  assign AccReady_o = w_acc_ready;
  assign BiasSel_o  = r_chan;
  assign OutValid_o = r_out_valid;
  assign Out_o      = r_out;
  assign OutChan_o  = r_out_chan;
  assign OutLast_o  = r_out_last;
  assign Ovf_o      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_l2_bias_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_bias_sequencer
//  Purpose  : Self-checking bench for l2_bias_sequencer. Two instances (ReLU
//             on and off) share stimulus; a frame-level reference model
//             predicts every result, handshake and the Done timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l2_bias_sequencer;

  localparam int CH = 8;
  localparam int PX = 2;
  localparam int NW = CH * PX;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        Start_i    = 1'b0;
  logic        AccValid_i = 1'b0;
  logic        OutReady_i = 1'b0;
  logic [21:0] Acc_i      = '0;

  logic [21:0] acc_arr  [NW];
  logic [21:0] bias_tbl [CH];
  int          widx;

  logic        busy_a, done_a, accrdy_a, outv_a, last_a, ovf_a;
  logic [2:0]  sel_a, ochan_a;
  logic [21:0] bias_a, out_a;
  logic        busy_b, done_b, accrdy_b, outv_b, last_b, ovf_b;
  logic [2:0]  sel_b, ochan_b;
  logic [21:0] bias_b, out_b;

  // Combinational bias muxes, one per instance
  assign bias_a = bias_tbl[sel_a];
  assign bias_b = bias_tbl[sel_b];

  l2_bias_sequencer #(.CHANNELS(CH), .PIX_NUM(PX), .RELU_EN(1)) dut_a (
    .clk(clk), .rstn(rstn), .Start_i(Start_i), .Busy_o(busy_a), .Done_o(done_a),
    .AccValid_i(AccValid_i), .AccReady_o(accrdy_a), .Acc_i(Acc_i),
    .BiasSel_o(sel_a), .Bias_i(bias_a), .OutValid_o(outv_a),
    .OutReady_i(OutReady_i), .Out_o(out_a), .OutChan_o(ochan_a),
    .OutLast_o(last_a), .Ovf_o(ovf_a)
  );

  l2_bias_sequencer #(.CHANNELS(CH), .PIX_NUM(PX), .RELU_EN(0)) dut_b (
    .clk(clk), .rstn(rstn), .Start_i(Start_i), .Busy_o(busy_b), .Done_o(done_b),
    .AccValid_i(AccValid_i), .AccReady_o(accrdy_b), .Acc_i(Acc_i),
    .BiasSel_o(sel_b), .Bias_i(bias_b), .OutValid_o(outv_b),
    .OutReady_i(OutReady_i), .Out_o(out_b), .OutChan_o(ochan_b),
    .OutLast_o(last_b), .Ovf_o(ovf_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: integer add, clamp to 22-bit signed range, optional ReLU
  function automatic logic [21:0] ref_out(input int acc, input int bias,
                                          input bit relu, output bit clamp);
    int s;
    s     = acc + bias;
    clamp = 1'b0;
    if (s > 2097151) begin
      s = 2097151;
      clamp = 1'b1;
    end else if (s < -2097152) begin
      s = -2097152;
      clamp = 1'b1;
    end
    if (relu && s < 0) s = 0;
    return 22'(s);
  endfunction

  function automatic logic [21:0] small_rand();
    return 22'(int'($urandom_range(0, 2000)) - 1000);
  endfunction

  // All outputs of both instances must sit at their reset/idle values
  task automatic check_zero();
    chk("rst_busy",   32'(busy_a),   0);  chk("rst_busy_b",   32'(busy_b),   0);
    chk("rst_done",   32'(done_a),   0);  chk("rst_done_b",   32'(done_b),   0);
    chk("rst_accrdy", 32'(accrdy_a), 0);  chk("rst_accrdy_b", 32'(accrdy_b), 0);
    chk("rst_outv",   32'(outv_a),   0);  chk("rst_outv_b",   32'(outv_b),   0);
    chk("rst_last",   32'(last_a),   0);  chk("rst_last_b",   32'(last_b),   0);
    chk("rst_ovf",    32'(ovf_a),    0);  chk("rst_ovf_b",    32'(ovf_b),    0);
    chk("rst_out",    32'(out_a),    0);  chk("rst_out_b",    32'(out_b),    0);
    chk("rst_ochan",  32'(ochan_a),  0);  chk("rst_ochan_b",  32'(ochan_b),  0);
    chk("rst_sel",    32'(sel_a),    0);  chk("rst_sel_b",    32'(sel_b),    0);
  endtask

  // One frame. mode 0: always valid/ready; 1: random valid/ready;
  // 2: ready low for cycles 5..9. start_at != 0 re-pulses Start_i mid-frame.
  task automatic run_frame(input int mode, input int start_at, input bit chk_done_cyc);
    logic [21:0] exp_a [NW];
    logic [21:0] exp_b [NW];
    bit ovf_exp, c, done_exp, fin, acc_hs, out_hs;
    int ridx, pending, cyc, done_cyc;
    ovf_exp = 1'b0; done_exp = 1'b0; fin = 1'b0;
    ridx = 0; pending = 0; done_cyc = -1;
    for (int i = 0; i < NW; i++) begin
      exp_a[i] = ref_out(int'($signed(acc_arr[i])), int'($signed(bias_tbl[i % CH])), 1'b1, c);
      if (c) ovf_exp = 1'b1;
      exp_b[i] = ref_out(int'($signed(acc_arr[i])), int'($signed(bias_tbl[i % CH])), 1'b0, c);
    end
    widx = 0;
    Start_i = 1'b1; AccValid_i = 1'b0; OutReady_i = 1'b1;
    @(posedge clk); @(negedge clk);
    Start_i = 1'b0;
    cyc = 1;
    while (!fin) begin
      AccValid_i = (widx < NW) && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      Acc_i      = (widx < NW) ? acc_arr[widx] : '0;
      case (mode)
        1:       OutReady_i = ($urandom_range(0, 2) != 0);
        2:       OutReady_i = !(cyc >= 5 && cyc < 10);
        default: OutReady_i = 1'b1;
      endcase
      Start_i = (cyc == start_at);
      #1;
      chk("busy",   32'(busy_a),   32'(ridx < NW));
      chk("busy_b", 32'(busy_b),   32'(ridx < NW));
      chk("accrdy",   32'(accrdy_a), 32'((widx < NW) && (pending == 0 || OutReady_i)));
      chk("accrdy_b", 32'(accrdy_b), 32'((widx < NW) && (pending == 0 || OutReady_i)));
      chk("outv",   32'(outv_a), 32'(pending != 0));
      chk("outv_b", 32'(outv_b), 32'(pending != 0));
      chk("done",   32'(done_a), 32'(done_exp));
      chk("done_b", 32'(done_b), 32'(done_exp));
      if (widx < NW) begin
        chk("sel",   32'(sel_a), 32'(widx % CH));
        chk("sel_b", 32'(sel_b), 32'(widx % CH));
      end
      if (pending != 0) begin
        chk("out",     32'(out_a),   32'(exp_a[ridx]));
        chk("out_b",   32'(out_b),   32'(exp_b[ridx]));
        chk("ochan",   32'(ochan_a), 32'(ridx % CH));
        chk("ochan_b", 32'(ochan_b), 32'(ridx % CH));
        chk("last",    32'(last_a),  32'(ridx == NW - 1));
        chk("last_b",  32'(last_b),  32'(ridx == NW - 1));
      end
      acc_hs = AccValid_i && (widx < NW) && (pending == 0 || OutReady_i);
      out_hs = (pending != 0) && OutReady_i;
      if (done_exp) begin
        fin = 1'b1;
        if (done_a) done_cyc = cyc;
      end
      @(posedge clk);
      done_exp = out_hs && (ridx + 1 == NW);
      if (out_hs) begin ridx++; pending--; end
      if (acc_hs) begin widx++; pending++; end
      @(negedge clk);
      cyc++;
      if (!fin && cyc > 300) begin
        chk("frame_timeout", 32'(cyc), 0);
        fin = 1'b1;
      end
    end
    Start_i = 1'b0; AccValid_i = 1'b0;
    if (chk_done_cyc) chk("done_cycle", 32'(done_cyc), 32'(NW + 2));
    chk("ovf",   32'(ovf_a), 32'(ovf_exp));
    chk("ovf_b", 32'(ovf_b), 32'(ovf_exp));
    chk("idle_busy", 32'(busy_a), 0);
  endtask

  task automatic fill_random(input bit wide);
    for (int i = 0; i < NW; i++) acc_arr[i] = wide ? 22'($urandom) : small_rand();
    for (int i = 0; i < CH; i++) bias_tbl[i] = wide ? 22'($urandom) : small_rand();
  endtask

  initial begin
    #1;
    check_zero();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Basic frame: biases 1..8, every accumulator 100
    for (int i = 0; i < CH; i++) bias_tbl[i] = 22'(i + 1);
    for (int i = 0; i < NW; i++) acc_arr[i] = 22'd100;
    run_frame(0, 0, 1'b1);

    // Saturation both ways plus a ReLU-clamped word in one frame
    fill_random(1'b0);
    bias_tbl[0] = 22'd5;       acc_arr[0] = 22'h1FFFFF;
    bias_tbl[1] = 22'h3FFFFF;  acc_arr[1] = 22'h200000;
    bias_tbl[2] = 22'd10;      acc_arr[2] = 22'(-50);
    run_frame(0, 0, 1'b0);

    // ReLU only, no clamping: sticky flag must have been cleared by Start
    fill_random(1'b0);
    bias_tbl[2] = 22'd10;      acc_arr[2] = 22'(-50);
    run_frame(0, 0, 1'b1);

    // Backpressure window mid-frame
    fill_random(1'b0);
    run_frame(2, 0, 1'b0);

    // Start pulse while running is ignored
    fill_random(1'b0);
    run_frame(0, 6, 1'b1);

    // Randomized handshakes and operand ranges
    for (int f = 0; f < 4; f++) begin
      fill_random(f[0]);
      run_frame(1, 0, 1'b0);
    end

    // Asynchronous reset after five accepted words
    fill_random(1'b0);
    bias_tbl[0] = 22'd5; acc_arr[0] = 22'h1FFFFF;
    widx = 0;
    Start_i = 1'b1; OutReady_i = 1'b1; AccValid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    Start_i = 1'b0;
    while (widx < 5) begin
      AccValid_i = 1'b1;
      Acc_i = acc_arr[widx];
      @(posedge clk);
      widx++;
      @(negedge clk);
    end
    AccValid_i = 1'b0;
    #1;
    chk("pre_rst_ovf",  32'(ovf_a),  1);
    chk("pre_rst_outv", 32'(outv_a), 1);
    chk("pre_rst_sel",  32'(sel_a),  5);
    #1 rstn = 1'b0;
    #1;
    check_zero();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_busy", 32'(busy_a), 0);
    chk("post_rst_done", 32'(done_a), 0);
    @(negedge clk);

    // Restart after reset begins at channel 0, pixel 0
    fill_random(1'b0);
    run_frame(0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_bias_sequencer.md
# l2_bias_sequencer

Sequences the layer-2 convolution bias stage: it accepts one accumulator word per output channel per pixel from the conv datapath and drives the channel select of the combinational layer-2 bias mux. It adds the returned 22-bit bias with signed saturation and optional ReLU, then presents the result on a valid/ready output stream. It sits between the layer-2 MAC array and the layer-2 output buffer, and runs one frame of `PIX_NUM` pixels × `CHANNELS` channels per `Start_i`.

## Interface
- `CHANNELS`, 8: channels per pixel, 1..8; the channel index wraps at `CHANNELS-1`.
- `PIX_NUM`, 64: output pixels per frame, ≥1.
- `RELU_EN`, 1: 1 = clamp negative results to 0.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `Start_i` in 1: frame start pulse; honoured only in IDLE.
- `Busy_o` out 1: high in RUN and DRAIN.
- `Done_o` out 1: one-cycle pulse when the frame is complete.
- `AccValid_i` in 1: accumulator word valid.
- `AccReady_o` out 1: sequencer accepts `Acc_i`.
- `Acc_i` in 22: signed accumulator value for the current channel.
- `BiasSel_o` out 3: channel select to the bias mux; equals the channel counter.
- `Bias_i` in 22: signed bias returned combinationally by the mux.
- `OutValid_o` out 1: result valid.
- `OutReady_i` in 1: downstream accepts the result.
- `Out_o` out 22: signed biased and activated result.
- `OutChan_o` out 3: channel index of `Out_o`.
- `OutLast_o` out 1: marks the final result of the frame.
- `Ovf_o` out 1: sticky saturation flag; cleared on an accepted `Start_i`.

## Operation
- States:
  - IDLE → RUN on `Start_i`. On that edge `chan`, `pix` and `Ovf_o` are cleared.
  - RUN → DRAIN on acceptance of the last word (`chan==CHANNELS-1 && pix==PIX_NUM-1`).
  - DRAIN → IDLE when the output register is empty, or is being emptied that cycle. `Done_o` pulses on that transition edge.
- `Start_i` is ignored in RUN and DRAIN.
- Acceptance:
  - `AccReady_o = (state==RUN) && (!OutValid_o || OutReady_i)`.
  - A word is accepted when `AccValid_i && AccReady_o`.
- `BiasSel_o = chan` at all times. Because the mux is combinational, `Bias_i` corresponds to `chan` in the same cycle.
- On acceptance:
  - `sum = sext23(Acc_i) + sext23(Bias_i)`.
  - Saturate to [-2^21, 2^21-1]. Set `Ovf_o` if clamping occurred.
  - If `RELU_EN`, replace a negative result with 0.
  - Register the result into `Out_o`, and `chan` into `OutChan_o`.
  - Set `OutValid_o`. Set `OutLast_o` if this is the last word.
  - Increment `chan`; on a wrap from `CHANNELS-1` to 0, increment `pix`.
- `OutValid_o` clears on `OutReady_i` unless a new word is accepted in the same cycle, in which case it stays high with new data.
- While `OutValid_o && !OutReady_i`, `Out_o`, `OutChan_o` and `OutLast_o` hold stable.
- Reset mid-frame: all state is discarded and the block returns to IDLE. No `Done_o` is issued.

## Timing
- Reset values:
  - state IDLE.
  - `Busy_o`, `Done_o`, `AccReady_o`, `OutValid_o`, `OutLast_o`, `Ovf_o` = 0.
  - `Out_o` = 0, `OutChan_o` = 0, `BiasSel_o` = 0.
- Latency: 1 cycle from accepted `Acc_i` to `OutValid_o`.
- Throughput: 1 word per cycle when `OutReady_i` is held high.
- `Busy_o` rises the cycle after `Start_i`.
- `Done_o` asserts the cycle after the last result handshake. With `OutReady_i` held high, that is 2 cycles after the last acceptance.
- Full frame with no stalls: `CHANNELS*PIX_NUM + 2` cycles from `Start_i` to `Done_o`.
- `AccReady_o` depends combinationally on `OutReady_i` (pass-through ready). There is no other combinational input-to-output path except `BiasSel_o`→`Bias_i` through the external mux.

## Structure
- Shared package `l2_conv_pkg`:
  - Width constants: `L2_ACC_W=22`, `L2_SEL_W=3`.
  - State enum `{IDLE, RUN, DRAIN}`.
  - A saturating-add function (23-bit intermediate to 22-bit result).
- Optional sub-module `l2_bias_addsat`: combinational add + saturate + ReLU, reused by the other layer bias stages.
- The bias mux is instantiated at the parent level, not inside this block.

## Test plan
- Each scenario uses `CHANNELS=8`, `PIX_NUM=2` unless stated otherwise, with the bias mux instantiated alongside in the bench.
- **Basic frame.** Biases 1..8, all `Acc_i=100`, `OutReady_i=1`.
  - `Out_o` sequence is 101..108, twice.
  - `OutChan_o` is 0..7, twice.
  - `OutLast_o` is high on the 16th output only.
  - `Done_o` pulses at cycle 18 after `Start_i`.
- **Saturation.**
  - `Acc_i=0x1FFFFF` with bias +5 → `Out_o=0x1FFFFF`, `Ovf_o=1`.
  - With `RELU_EN=0`: `Acc_i=-2^21` with bias -1 → `Out_o=0x200000`.
- **ReLU.** `Acc_i=-50`, bias 10 → `Out_o=0`, and `Ovf_o` stays 0.
- **Backpressure.**
  - Hold `OutReady_i=0` for 5 cycles mid-frame.
  - `AccReady_o=0` and `Out_o` stays stable for those cycles.
  - No word is lost or duplicated; the order is still 0..7.
- **Start while busy.** Pulse `Start_i` in RUN → ignored; counters and the output sequence are unchanged.
- **Async reset mid-frame.** Drop `rstn` after 5 accepts.
  - All outputs go to 0 immediately and the state is IDLE.
  - The next `Start_i` restarts at chan 0, pix 0.
